// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and default constants for the SPI master slice
package spi_pkg;

    localparam int SPI_DATA_W_DEF = 16;
    localparam int SPI_NUM_SS_DEF = 4;
    localparam int SPI_DIV_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Select index width; a single slave still gets a one-bit port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period divider, SCLK level and leading/trailing edge strobes
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             load_level,
    input  logic             run,
    input  logic             toggle,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             lead_edge,
    output logic             trail_edge,
    output logic             sclk
);

    logic [DIV_W-1:0] cnt;
    logic             phase;

    // cnt never passes div, so an all-ones divider cannot wrap.
    assign tick       = run && (cnt == div);
    assign lead_edge  = tick && toggle && !phase;
    assign trail_edge = tick && toggle && phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            phase <= 1'b0;
            sclk  <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            phase <= 1'b0;
            sclk  <= load_level;
        end else if (!run) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
            if (toggle) begin
                sclk  <= ~sclk;
                phase <= ~phase;
            end
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - configurable SPI master (modes 0-3, divider, NUM_SS selects)
// Optional SPI_LSB_FIRST_EN adds lsb_first to choose LSB-first shift/receive order.
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W_DEF,
    parameter int NUM_SS = SPI_NUM_SS_DEF,
    parameter int DIV_W  = SPI_DIV_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [sel_width(NUM_SS)-1:0] ss_sel,
    input  logic                         cpol,
    input  logic                         cpha,
    input  logic [DIV_W-1:0]             clk_div,
    input  logic [DATA_W-1:0]            data_in,
`ifdef SPI_LSB_FIRST_EN
    input  logic                         lsb_first,
`endif
    input  logic                         miso,
    output logic                         sclk,
    output logic                         mosi,
    output logic [NUM_SS-1:0]            ss_n,
    output logic [DATA_W-1:0]            data_out,
    output logic                         busy,
    output logic                         done
);

    localparam int EDGES  = 2 * DATA_W;
    localparam int ECNT_W = $clog2(EDGES + 1);

    spi_state_t        state;
    spi_mode_t         mode_q;
    logic [DIV_W-1:0]  div_q;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [ECNT_W-1:0] edge_cnt;
    logic              lsb_in;
    logic              lsb_q;
    logic              sel_ok;
    logic              accept;
    logic              tick;
    logic              lead_edge;
    logic              trail_edge;
    logic              shift_edge;
    logic              sample_edge;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsb_q <= 1'b0;
        end else if (accept) begin
            lsb_q <= lsb_first;
        end
    end
`else
    assign lsb_in = 1'b0;
    assign lsb_q  = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    assign sel_ok = (32'(ss_sel) < 32'(NUM_SS));
    // The done cycle is excluded so a start coincident with done waits one cycle.
    assign accept = start && (state == ST_IDLE) && !done && sel_ok;

    assign shift_edge  = mode_q.cpha ? lead_edge  : trail_edge;
    assign sample_edge = mode_q.cpha ? trail_edge : lead_edge;

    spi_clk_gen #(
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_level (cpol),
        .run        (state != ST_IDLE),
        .toggle     (state == ST_XFER),
        .div        (div_q),
        .tick       (tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .sclk       (sclk)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            mode_q   <= '0;
            div_q    <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
            mosi     <= 1'b0;
            ss_n     <= '1;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_SETUP;
                        busy        <= 1'b1;
                        mode_q.cpol <= cpol;
                        mode_q.cpha <= cpha;
                        div_q       <= clk_div;
                        ss_n        <= ~(NUM_SS'(1) << ss_sel);
                        mosi        <= lsb_in ? data_in[0] : data_in[DATA_W-1];
                        // cpha=0 presents bit 0 now; cpha=1 presents it on the first leading edge.
                        tx_sr       <= cpha ? data_in : shift_out(data_in, lsb_in);
                        rx_sr       <= '0;
                        edge_cnt    <= '0;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (tick) begin
                        edge_cnt <= edge_cnt + ECNT_W'(1);
                        if (shift_edge) begin
                            mosi  <= lsb_q ? tx_sr[0] : tx_sr[DATA_W-1];
                            tx_sr <= shift_out(tx_sr, lsb_q);
                        end
                        if (sample_edge) begin
                            rx_sr <= lsb_q ? {miso, rx_sr[DATA_W-1:1]}
                                           : {rx_sr[DATA_W-2:0], miso};
                        end
                        if (edge_cnt == ECNT_W'(EDGES - 1)) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        ss_n     <= '1;
                        data_out <= rx_sr;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    a_one_select: assert property (@(posedge clk) disable iff (!rst) $onehot0(~ss_n));
    a_busy_state: assert property (@(posedge clk) disable iff (!rst) busy == (state != ST_IDLE));
    a_done_idle:  assert property (@(posedge clk) disable iff (!rst) done |-> !busy);

endmodule
